// File: rtl/eci_pkt_serializer_pkg.sv
// ECI command definitions shared by the packet serializer, its interface and its bench:
// word/dmask/cache-line types, the generic command header layout and packet-size helpers.
package eci_cmd_defs;

  localparam int N_SCL                 = 4;
  localparam int WORDS_PER_SCL         = 4;
  localparam int ECI_CL_WORDS          = N_SCL * WORDS_PER_SCL;
  localparam int MAX_WORDS             = 1 + ECI_CL_WORDS;
  localparam int ECI_PACKET_SIZE_WIDTH = 5;
  localparam int ECI_SCL_WIDTH         = 3;
  localparam int SCL_IDX_W             = $clog2(N_SCL);
  localparam int WIDX_W                = $clog2(WORDS_PER_SCL);

  typedef logic [63:0]                eci_word_t;
  typedef logic [N_SCL-1:0]           eci_dmask_t;
  typedef logic [ECI_CL_WORDS*64-1:0] eci_cl_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [5:0]  hreq_id;
    eci_dmask_t  dmask;
    logic        ns;
    logic [7:0]  rsvd;
    logic [39:0] cl_addr;
  } eci_generic_cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} ser_state_e;

  function automatic eci_dmask_t get_dmask(input eci_word_t hdr);
    eci_generic_cmd_t cmd;
    cmd = eci_generic_cmd_t'(hdr);
    return cmd.dmask;
  endfunction

  function automatic logic [ECI_SCL_WIDTH-1:0] get_scl_from_dmask(input eci_dmask_t dmask);
    logic [ECI_SCL_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_SCL; i++) cnt = cnt + ECI_SCL_WIDTH'(dmask[i]);
    return cnt;
  endfunction

  // One header word plus four data words per selected sub-cache-line.
  function automatic logic [ECI_PACKET_SIZE_WIDTH-1:0] get_num_words_from_scl(
    input logic [ECI_SCL_WIDTH-1:0] num_scl);
    return ECI_PACKET_SIZE_WIDTH'(1) + {num_scl, 2'b00};
  endfunction

endpackage

// File: rtl/eci_pkt_serializer_if.sv
// Packet-in / word-out bus of the ECI packet serializer; slave is the serializer's view.
interface eci_pkt_serializer_if;
  import eci_cmd_defs::*;

  eci_word_t                        s_pkt_hdr;
  eci_cl_t                          s_pkt_data;
  logic                             s_pkt_valid;
  logic                             s_pkt_ready;
  eci_word_t                        m_word;
  logic                             m_valid;
  logic                             m_last;
  logic [ECI_PACKET_SIZE_WIDTH-1:0] m_size;
  logic                             m_ready;

  modport master (
    output s_pkt_hdr, s_pkt_data, s_pkt_valid, m_ready,
    input  s_pkt_ready, m_word, m_valid, m_last, m_size
  );

  modport slave (
    input  s_pkt_hdr, s_pkt_data, s_pkt_valid, m_ready,
    output s_pkt_ready, m_word, m_valid, m_last, m_size
  );

endinterface

// File: rtl/eci_pkt_ser_skid.sv
// Two-entry skid buffer: registered ready (no comb path from out_ready_i) and full throughput.
module eci_pkt_ser_skid #(
  parameter int W = 70
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/eci_pkt_serializer.sv
// Serializes one ECI packet (header + dmask-selected SCLs) into 64-bit words, header first.
// Optional ECI_PKT_SER_OUT_REG_EN inserts a skid register on the word output (+1 cycle latency).
module eci_pkt_serializer
  import eci_cmd_defs::*;
(
  input logic                 aclk,
  input logic                 aresetn,
  eci_pkt_serializer_if.slave bus
);

  ser_state_e                       state_q, state_d;
  eci_dmask_t                       dmask_q, dmask_d;
  logic [WIDX_W-1:0]                widx_q, widx_d;
  logic [ECI_PACKET_SIZE_WIDTH-1:0] size_q, size_d;
  eci_word_t                        hdr_q, hdr_d;
  eci_cl_t                          data_q, data_d;

  logic                             fsm_valid, fsm_last, fsm_ready, s_ready;
  eci_word_t                        fsm_word;
  logic [SCL_IDX_W-1:0]             scl_sel, scl_top;

  function automatic logic [SCL_IDX_W-1:0] lowest_set(input eci_dmask_t m);
    lowest_set = '0;
    for (int i = N_SCL - 1; i >= 0; i--) if (m[i]) lowest_set = SCL_IDX_W'(i);
  endfunction

  function automatic logic [SCL_IDX_W-1:0] highest_set(input eci_dmask_t m);
    highest_set = '0;
    for (int i = 0; i < N_SCL; i++) if (m[i]) highest_set = SCL_IDX_W'(i);
  endfunction

  assign scl_sel = lowest_set(dmask_q);
  assign scl_top = highest_set(dmask_q);

  always_comb begin
    state_d   = state_q;
    dmask_d   = dmask_q;
    widx_d    = widx_q;
    size_d    = size_q;
    hdr_d     = hdr_q;
    data_d    = data_q;
    fsm_valid = 1'b0;
    fsm_last  = 1'b0;
    fsm_word  = '0;
    s_ready   = 1'b0;
    unique case (state_q)
      ST_IDLE: s_ready = 1'b1;
      ST_HDR: begin
        fsm_valid = 1'b1;
        fsm_word  = hdr_q;
        fsm_last  = (dmask_q == '0);
        if (fsm_ready) state_d = (dmask_q == '0) ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        fsm_valid = 1'b1;
        fsm_word  = data_q[{scl_sel, widx_q, 6'b0} +: 64];
        fsm_last  = (widx_q == WIDX_W'(WORDS_PER_SCL - 1)) && (scl_sel == scl_top);
        if (fsm_ready) begin
          if (widx_q == WIDX_W'(WORDS_PER_SCL - 1)) begin
            dmask_d[scl_sel] = 1'b0;
            widx_d           = '0;
            if (fsm_last) state_d = ST_IDLE;
          end else begin
            widx_d = widx_q + WIDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Accepting in the last-beat cycle lets the next header follow without a bubble.
    if (fsm_valid && fsm_ready && fsm_last) s_ready = 1'b1;
    if (bus.s_pkt_valid && s_ready) begin
      hdr_d   = bus.s_pkt_hdr;
      data_d  = bus.s_pkt_data;
      dmask_d = get_dmask(bus.s_pkt_hdr);
      widx_d  = '0;
      size_d  = get_num_words_from_scl(get_scl_from_dmask(get_dmask(bus.s_pkt_hdr)));
      state_d = ST_HDR;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      dmask_q <= '0;
      widx_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      dmask_q <= dmask_d;
      widx_q  <= widx_d;
      size_q  <= size_d;
    end
  end

  always_ff @(posedge aclk) begin
    hdr_q  <= hdr_d;
    data_q <= data_d;
  end

  assign bus.s_pkt_ready = s_ready;

`ifdef ECI_PKT_SER_OUT_REG_EN
  localparam int SKID_W = 64 + 1 + ECI_PACKET_SIZE_WIDTH;
  logic [SKID_W-1:0] skid_out;

  eci_pkt_ser_skid #(.W(SKID_W)) u_skid (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_valid_i  (fsm_valid),
    .in_data_i   ({fsm_word, fsm_last, size_q}),
    .in_ready_o  (fsm_ready),
    .out_valid_o (bus.m_valid),
    .out_data_o  (skid_out),
    .out_ready_i (bus.m_ready)
  );

  assign {bus.m_word, bus.m_last, bus.m_size} = skid_out;
`else
  assign bus.m_word  = fsm_word;
  assign bus.m_valid = fsm_valid;
  assign bus.m_last  = fsm_last;
  assign bus.m_size  = size_q;
  assign fsm_ready   = bus.m_ready;
`endif

endmodule

// File: tb/tb_eci_pkt_serializer.sv
// Randomized bench for eci_pkt_serializer: a queue-based packet model predicts every output beat.
module tb_eci_pkt_serializer;
  import eci_cmd_defs::*;

  typedef struct {
    eci_word_t  w;
    logic       last;
    logic [4:0] size;
  } beat_t;

  logic aclk;
  logic aresetn;
  eci_pkt_serializer_if bus();

  eci_pkt_serializer dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc   = 0;
  int     rdy_mode = 0;
  beat_t  exp_q[$];
  int     beat_cyc[$];
  logic   hold = 1'b0;
  beat_t  hold_b;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // m_ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        1:       bus.m_ready = ~bus.m_ready;
        2:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: handshake decided at the next rising edge, checked here on the falling edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", bus.m_valid, 1'b1);
        chk("stall_word", bus.m_word, hold_b.w);
        chk("stall_last", bus.m_last, hold_b.last);
        chk("stall_size", bus.m_size, hold_b.size);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected_valid", bus.m_valid, 1'b0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_word", bus.m_word, e.w);
          chk("beat_last", bus.m_last, e.last);
          chk("beat_size", bus.m_size, e.size);
        end
        beat_cyc.push_back(cyc);
        hold = 1'b0;
      end else if (bus.m_valid) begin
        hold        = 1'b1;
        hold_b.w    = bus.m_word;
        hold_b.last = bus.m_last;
        hold_b.size = bus.m_size;
      end else begin
        hold = 1'b0;
      end
    end
  end

  function automatic eci_word_t make_hdr(input eci_dmask_t dm);
    eci_generic_cmd_t c;
    c       = eci_generic_cmd_t'({$urandom, $urandom});
    c.dmask = dm;
    return eci_word_t'(c);
  endfunction

  function automatic eci_cl_t rand_cl();
    eci_cl_t d;
    for (int i = 0; i < 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Reference: header, then every selected SCL's four words in ascending SCL order.
  task automatic model_pkt(input eci_word_t hdr, input eci_cl_t data);
    eci_generic_cmd_t c;
    beat_t            q[$];
    int               nscl;
    int               sz;
    c    = eci_generic_cmd_t'(hdr);
    nscl = 0;
    for (int s = 0; s < 4; s++) if (c.dmask[s]) nscl++;
    sz = 1 + 4 * nscl;
    q.push_back('{hdr, 1'b0, 5'(sz)});
    for (int s = 0; s < 4; s++)
      if (c.dmask[s])
        for (int k = 0; k < 4; k++) q.push_back('{data[64*(4*s+k) +: 64], 1'b0, 5'(sz)});
    q[q.size()-1].last = 1'b1;
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  task automatic send_pkt(input eci_word_t hdr, input eci_cl_t data);
    logic acc;
    int   n;
    model_pkt(hdr, data);
    bus.s_pkt_hdr   = hdr;
    bus.s_pkt_data  = data;
    bus.s_pkt_valid = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      acc = bus.s_pkt_ready;
      @(posedge aclk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) chk("pkt_accept_timeout", acc, 1'b1);
    bus.s_pkt_valid = 1'b0;
    bus.s_pkt_hdr   = {$urandom, $urandom};
    bus.s_pkt_data  = rand_cl();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    chk("drain_beats_left", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    eci_cl_t d;
    int      n;
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    eci_cl_t cnt_cl;
    int      n;
    bus.s_pkt_valid = 1'b0;
    bus.s_pkt_hdr   = '0;
    bus.s_pkt_data  = '0;
    aresetn         = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_pkt_ready", bus.s_pkt_ready, 1'b1);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_last", bus.m_last, 1'b0);
    chk("rst_m_word", bus.m_word, 64'h0);
    chk("rst_m_size", bus.m_size, 5'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Header-only packet
    rdy_mode = 0;
    send_pkt(make_hdr(4'b0000), rand_cl());
    @(negedge aclk);
    chk("hdr_only_s_ready", bus.s_pkt_ready, 1'b1);
`ifdef ECI_PKT_SER_OUT_REG_EN
    @(negedge aclk);
`endif
    chk("hdr_latency_valid", bus.m_valid, 1'b1);
    chk("hdr_only_last", bus.m_last, 1'b1);
    drain();

    // Full line, data word k = k
    for (int k = 0; k < 16; k++) cnt_cl[64*k +: 64] = 64'(k);
    send_pkt(make_hdr(4'b1111), cnt_cl);
    drain();

    // Sparse mask
    send_pkt(make_hdr(4'b1010), cnt_cl);
    drain();

    // Stalls with toggling m_ready
    rdy_mode = 1;
    send_pkt(make_hdr(4'b0001), rand_cl());
    drain();

    // Back-to-back, no gap expected
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;
    beat_cyc.delete();
    send_pkt(make_hdr(4'b0001), rand_cl());
    send_pkt(make_hdr(4'b1000), rand_cl());
    drain();
    chk("b2b_beats", beat_cyc.size(), 10);
    if (beat_cyc.size() >= 10) chk("b2b_span", beat_cyc[9] - beat_cyc[0], 9);

    // Reset in the middle of a full packet
    beat_cyc.delete();
    send_pkt(make_hdr(4'b1111), rand_cl());
    n = 0;
    while (beat_cyc.size() < 3 && n < 100) begin
      @(posedge aclk);
      n++;
    end
    #1;
    aresetn = 1'b0;
    #1;
    chk("midrst_m_valid", bus.m_valid, 1'b0);
    chk("midrst_m_last", bus.m_last, 1'b0);
    chk("midrst_m_size", bus.m_size, 5'd0);
    chk("midrst_s_ready", bus.s_pkt_ready, 1'b1);
    exp_q.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send_pkt(make_hdr(4'b0110), rand_cl());
    drain();

    // Random packets and downstream back-pressure
    for (int p = 0; p < 30; p++) begin
      rdy_mode = $urandom_range(0, 2);
      send_pkt(make_hdr(4'($urandom_range(0, 15))), rand_cl());
      if ($urandom_range(0, 3) == 0) drain();
    end
    rdy_mode = 2;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
